count_sample_fifo: RTL and testbench

//  Stage directly downstream of the 8-bit up counter in RR0. Samples the counter value every

---
 rtl/count_sample_fifo.sv | 166 ++++++++++++++++
 tb/tb_count_sample_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : count_sample_fifo
//  Purpose  : Samples an upstream counter every PERIOD cycles while running.
//             Each sample is tagged with a wrap flag and buffered in a
//             DEPTH-entry first-word-fall-through FIFO. The FIFO is drained
//             through a valid/ready port. The block also keeps a saturating
//             wrap count and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module count_sample_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int PERIOD = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [WIDTH-1:0]         cnt_in,
    output logic [WIDTH:0]           out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     overflow,
    output logic [7:0]               wrap_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic [7:0]         wrap_cnt_q, wrap_cnt_d;
    logic               overflow_q, overflow_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [WIDTH:0]     mem_q [DEPTH];

    logic               arm;
    logic               sample;
    logic               wrap_flag;
    logic               full;
    logic               pop;
    logic               push;

    // Event decode: arming, sample instants, FIFO handshake.
    // A stop coinciding with a sample instant suppresses the sample.
    assign arm       = (state_q == S_IDLE) && start && !stop;
    assign sample    = (state_q == S_RUN) && !stop && (per_cnt_q == PW'(PERIOD - 1));
    assign wrap_flag = prev_valid_q && (cnt_in < prev_q);
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = sample && (!full || pop);

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = (state_q == S_RUN);
    assign overflow  = overflow_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign level     = level_q;

    // Next-state logic for the FSM, period counter, sample tracking and FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wrap_cnt_d   = wrap_cnt_q;
        overflow_d   = overflow_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d      = S_RUN;
                    per_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                    wrap_cnt_d   = '0;
                    overflow_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    per_cnt_d = '0;
                end else if (sample) begin
                    per_cnt_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sample bookkeeping happens whether or not the sample fits in the FIFO.
        if (sample) begin
            prev_d       = cnt_in;
            prev_valid_d = 1'b1;
            if (wrap_flag && (wrap_cnt_q != 8'd255)) begin
                wrap_cnt_d = wrap_cnt_q + 8'd1;
            end
            if (full && !pop) begin
                overflow_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            per_cnt_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wrap_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wrap_cnt_q   <= wrap_cnt_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // FIFO storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wrap_flag, cnt_in};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_sample_fifo
//  Purpose  : Directed self-checking bench for count_sample_fifo
//             (PERIOD=4, DEPTH=8, WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_sample_fifo;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  cnt_in;
    logic [8:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  wrap_cnt;
    logic [3:0]  level;

    int n_assert;
    int n_fail;
    int edge_n;
    bit cnt_auto;

    count_sample_fifo #(
        .WIDTH  (8),
        .DEPTH  (8),
        .PERIOD (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cnt_in    (cnt_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow),
        .wrap_cnt  (wrap_cnt),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        if (cnt_auto) cnt_in = 8'(edge_n + 1);
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e1 [3];
        logic [8:0] e2 [3];
        n_assert  = 0;
        n_fail    = 0;
        edge_n    = 0;
        cnt_auto  = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cnt_in    = 8'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_level",    32'(level),     32'd0);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_data",     32'(out_data),  32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_wrap",     32'(wrap_cnt),  32'd0);
        reset = 1'b1;

        // 1: cnt_in follows the edge index; start on edge 10 -> samples 14,18,22
        cnt_auto = 1'b1;
        while (edge_n < 9) tick();
        start = 1'b1;
        tick();                         // edge 10
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (3) tick();              // edge 13
        chk("t1_level_pre", 32'(level), 32'd0);
        tick();                         // edge 14
        chk("t1_level1", 32'(level),     32'd1);
        chk("t1_valid",  32'(out_valid), 32'd1);
        chk("t1_head",   32'(out_data),  32'h00E);
        repeat (8) tick();              // edge 22
        chk("t1_level3",  32'(level),    32'd3);
        chk("t1_stable",  32'(out_data), 32'h00E);
        stop = 1'b1;
        tick();                         // edge 23
        stop = 1'b0;
        cnt_auto = 1'b0;
        chk("t1_busy_off", 32'(busy),     32'd0);
        chk("t1_wrap",     32'(wrap_cnt), 32'd0);
        e1 = '{9'h00E, 9'h012, 9'h016};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_pop%0d", i), 32'(out_data), 32'(e1[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("t1_empty_level", 32'(level),     32'd0);
        chk("t1_empty_valid", 32'(out_valid), 32'd0);
        chk("t1_empty_data",  32'(out_data),  32'd0);

        // 2: samples 250, 254, 2 -> third one carries the wrap flag
        cnt_in = 8'd250;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        cnt_in = 8'd254;
        repeat (4) tick();
        cnt_in = 8'd2;
        repeat (4) tick();
        chk("t2_level", 32'(level),    32'd3);
        chk("t2_wrap",  32'(wrap_cnt), 32'd1);
        e2 = '{9'h0FA, 9'h0FE, 9'h102};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_pop%0d", i), 32'(out_data), 32'(e2[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("t2_drained", 32'(level), 32'd0);

        // 3: nine samples with no consumer -> FIFO fills, ninth dropped
        for (int i = 0; i < 9; i++) begin
            cnt_in = 8'(10 + i);
            tick();
            chk($sformatf("t3_ovf%0d", i),   32'(overflow), (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("t3_level%0d", i), 32'(level),    (i < 8) ? 32'(i + 1) : 32'd8);
            repeat (3) tick();
        end
        chk("t3_wrap", 32'(wrap_cnt), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_busy",  32'(busy),  32'd0);
        chk("t3_full",  32'(level), 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_pop%0d", i), 32'(out_data), 32'(10 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_level0",   32'(level),     32'd0);
        chk("t3_valid0",   32'(out_valid), 32'd0);
        chk("t3_ovf_keep", 32'(overflow),  32'd1);

        // 4: full FIFO, pop and push on the same sample edge
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_ovf_clr",  32'(overflow), 32'd0);
        chk("t4_wrap_clr", 32'(wrap_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cnt_in = 8'(50 + i);
            repeat (4) tick();
        end
        chk("t4_full", 32'(level), 32'd8);
        repeat (3) tick();
        cnt_in    = 8'd99;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_level", 32'(level),    32'd8);
        chk("t4_ovf",   32'(overflow), 32'd0);
        chk("t4_head",  32'(out_data), 32'h033);

        // 5a: start together with stop in IDLE does nothing
        stop = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_start_stop_idle", 32'(busy), 32'd0);

        // 6: reset in the middle of a run with five entries queued
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        chk("t6_level3", 32'(level),    32'd3);
        chk("t6_head",   32'(out_data), 32'h038);
        cnt_in = 8'd200;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        cnt_in = 8'd5;
        repeat (4) tick();
        chk("t6_level5", 32'(level),    32'd5);
        chk("t6_wrap1",  32'(wrap_cnt), 32'd1);
        chk("t6_busy1",  32'(busy),     32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_level", 32'(level),     32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_wrap",  32'(wrap_cnt),  32'd0);
        chk("t6_data",  32'(out_data),  32'd0);

        // 5b: stop on a sample edge suppresses the push
        cnt_in = 8'd77;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_level", 32'(level), 32'd0);
        chk("t5_stop_busy",  32'(busy),  32'd0);
        repeat (6) tick();
        chk("t5_idle_nopush", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
